data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have ports req0/req1  input  1  access request from requester 0/1, level, held until done.
REQ-006 The block SHALL have ports we0/we1  input  1  1 = write, 0 = read, valid with req.
REQ-007 The block SHALL have ports addr0/addr1  input  ADDR_W  word address, valid with req.
REQ-008 The block SHALL have ports wdata0/wdata1  input  DATA_W  write data, valid with req and we.
REQ-009 The block SHALL have ports done0/done1  output  1  one-cycle completion pulse to requester 0/1.
REQ-010 The block SHALL have ports rdata0/rdata1  output  DATA_W  read result, valid while the matching done is 1 after a read.
REQ-011 The block SHALL have port busy  output  1  1 whenever state is not IDLE.
REQ-012 The block SHALL have ports mem_addr (ADDR_W), mem_write_data (DATA_W), mem_memwrite (1), mem_memread (1), all outputs, which drive the data memory's addr, write_data, memwrite and memread inputs.
REQ-013 The block SHALL have port mem_read_data  input  DATA_W  data memory read_data, which is registered and valid one edge after memread is sampled.

Function
REQ-014 The block SHALL implement FSM states IDLE, ISSUE, WAIT and RESP, with at most one access in flight.
REQ-015 In IDLE, when any req is 1, the block SHALL grant one requester and, at that edge, latch its id, we, addr and wdata, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: a lone requester wins; when both request, the requester not granted last wins; a last-granted pointer SHALL update on each grant.
REQ-017 Requester inputs SHALL be sampled only at the grant edge; later changes SHALL NOT affect the in-flight access.
REQ-018 In ISSUE, the block SHALL drive mem_addr and mem_write_data from the latched values, and assert mem_memwrite = latched we and mem_memread = !latched we, for exactly one cycle.
REQ-019 Outside ISSUE, mem_memwrite and mem_memread SHALL be 0; mem_addr and mem_write_data SHALL hold their last values.
REQ-020 For a write, the FSM SHALL go ISSUE -> RESP; for a read, it SHALL go ISSUE -> WAIT -> RESP.
REQ-021 In WAIT, the block SHALL capture mem_read_data into the granted requester's rdata register at the end of the cycle.
REQ-022 In RESP, the block SHALL assert done of the granted requester only, for exactly one cycle, then go to IDLE.
REQ-023 An access SHALL complete at the edge ending RESP; the requester updates req at that edge, and a still-high req SHALL be treated as a new request.
REQ-024 Latency from grant edge to done cycle SHALL be 2 cycles for a write (done in cycle k+2) and 3 cycles for a read (done in cycle k+3), with no stalls.
REQ-025 rdataN SHALL hold its last captured value until the next read by requester N; a write SHALL NOT change either rdata.
REQ-026 Back-to-back accesses SHALL have one IDLE cycle between RESP and the next ISSUE, giving a write throughput of 1 per 3 cycles and a read throughput of 1 per 4 cycles.
REQ-027 A req arriving while busy SHALL wait, and SHALL NOT be lost, provided the requester holds it.

Reset
REQ-028 While rst is 1, the block SHALL hold state IDLE with done0, done1, busy, mem_memwrite and mem_memread at 0, and rdata0, rdata1, mem_addr and mem_write_data at 0.
REQ-029 Reset SHALL set the last-granted pointer to requester 1, so requester 0 wins the first tie.
REQ-030 Reset asserted mid-access SHALL abort the access immediately with no done pulse; a write aborted in ISSUE SHALL NOT be guaranteed to reach memory.

Verification
REQ-031 The bench SHALL cover: reset released, req0=1, we0=1, addr0=5, wdata0=0xDEADBEEF -> mem_memwrite=1 with mem_addr=5 in cycle k+1, done0 in cycle k+2, done1 never asserted.
REQ-032 The bench SHALL cover: read of addr 5 by requester 1 after that write -> mem_memread=1 in cycle k+1, done1 with rdata1=0xDEADBEEF in cycle k+3, rdata0 unchanged.
REQ-033 The bench SHALL cover: req0 and req1 both held high for 4 accesses after reset -> grants in the order 0,1,0,1 and no starvation.
REQ-034 The bench SHALL cover: addr0 changed in the ISSUE cycle of a requester-0 read -> mem_addr and the returned data reflect the originally latched address.
REQ-035 The bench SHALL cover: rst pulsed during WAIT of a read -> no done pulse, all outputs 0 and state IDLE; the next request is served normally with requester 0 winning a tie.
REQ-036 The bench SHALL cover: a requester keeping req high after done -> a new access is granted in the following IDLE cycle, and exactly one done is produced per access.

Source files
------------

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | data_memory_arbiter                                                     |
// | Round-robin two-requester arbiter in front of a registered data memory. |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module data_memory_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_id;
  logic                r_we;
  logic                r_last;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                w_grant;
  logic                w_gnt_id;

  // On a tie the requester not granted last wins; otherwise the lone requester.
  assign w_gnt_id = (req0 && req1) ? ~r_last : req1;
  assign w_grant  = (r_state == S_IDLE) && (req0 || req1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req0 || req1) w_next = S_ISSUE;
      S_ISSUE: w_next = r_we ? S_RESP : S_WAIT;
      S_WAIT:  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request fields are captured only at the grant edge and held for the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_id    <= w_gnt_id;
      r_we    <= w_gnt_id ? we1 : we0;
      r_last  <= w_gnt_id;
      r_addr  <= w_gnt_id ? addr1 : addr0;
      r_wdata <= w_gnt_id ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == S_WAIT) begin
      if (r_id) r_rdata1 <= mem_read_data;
      else      r_rdata0 <= mem_read_data;
    end
  end

  // The latched address/data only change at a grant, so they hold between accesses.
  assign mem_addr       = r_addr;
  assign mem_write_data = r_wdata;
  assign mem_memwrite   = (r_state == S_ISSUE) && r_we;
  assign mem_memread    = (r_state == S_ISSUE) && !r_we;

  assign done0  = (r_state == S_RESP) && !r_id;
  assign done1  = (r_state == S_RESP) && r_id;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;
  assign busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_data_memory_arbiter                                                  |
// | Directed self-checking bench with a registered-read memory model.       |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_data_memory_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              done0, done1, busy;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_memwrite, mem_memread;
  logic [DATA_W-1:0] mem_read_data;

  int checks = 0;
  int errors = 0;
  int dones  = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_memwrite) mem[mem_addr] <= mem_write_data;
    if (mem_memread)  mem_read_data <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_done0"}, done0, 1'b0);
    chk({tag, "_done1"}, done1, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_memwrite"}, mem_memwrite, 1'b0);
    chk({tag, "_memread"}, mem_memread, 1'b0);
    chk({tag, "_rdata0"}, rdata0, 32'h0);
    chk({tag, "_rdata1"}, rdata1, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 10'h0);
    chk({tag, "_mem_wdata"}, mem_write_data, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_read_data = '0;
    tick(); tick();
    chk_idle_zero("reset");
    rst = 1'b0;

    // Write 0xDEADBEEF to addr 5 from requester 0
    req0 = 1; we0 = 1; addr0 = 10'd5; wdata0 = 32'hDEADBEEF;
    tick();
    chk("wr_memwrite", mem_memwrite, 1'b1);
    chk("wr_memread", mem_memread, 1'b0);
    chk("wr_mem_addr", mem_addr, 10'd5);
    chk("wr_mem_wdata", mem_write_data, 32'hDEADBEEF);
    chk("wr_done0_k1", done0, 1'b0);
    chk("wr_busy", busy, 1'b1);
    tick();
    chk("wr_done0_k2", done0, 1'b1);
    chk("wr_done1_k2", done1, 1'b0);
    chk("wr_memwrite_k2", mem_memwrite, 1'b0);
    req0 = 0;
    tick();
    chk("wr_idle_busy", busy, 1'b0);
    chk("wr_idle_done0", done0, 1'b0);
    chk("wr_idle_done1", done1, 1'b0);

    // Read addr 5 from requester 1
    req1 = 1; we1 = 0; addr1 = 10'd5;
    tick();
    chk("rd_memread", mem_memread, 1'b1);
    chk("rd_memwrite", mem_memwrite, 1'b0);
    chk("rd_mem_addr", mem_addr, 10'd5);
    tick();
    chk("rd_done1_k2", done1, 1'b0);
    chk("rd_memread_k2", mem_memread, 1'b0);
    tick();
    chk("rd_done1_k3", done1, 1'b1);
    chk("rd_done0_k3", done0, 1'b0);
    chk("rd_rdata1", rdata1, 32'hDEADBEEF);
    chk("rd_rdata0", rdata0, 32'h0);
    req1 = 0;
    tick();
    chk("rd_idle_done1", done1, 1'b0);
    chk("rd_rdata1_hold", rdata1, 32'hDEADBEEF);

    // Fresh reset, then both requesters hold writes: order 0,1,0,1
    rst = 1; tick(); rst = 0;
    req0 = 1; we0 = 1; addr0 = 10'd10; wdata0 = 32'hA0A0A0A0;
    req1 = 1; we1 = 1; addr1 = 10'd11; wdata1 = 32'hB1B1B1B1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_mem_addr", mem_addr, (i % 2 == 0) ? 10'd10 : 10'd11);
      chk("rr_memwrite", mem_memwrite, 1'b1);
      tick();
      chk("rr_done0", done0, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("rr_done1", done1, (i % 2 == 1) ? 1'b1 : 1'b0);
      if (i == 3) begin
        req0 = 0; req1 = 0;
      end
      tick();
      chk("rr_idle_busy", busy, 1'b0);
    end

    // Requester 0 reads addr 10, then changes addr0 during ISSUE
    req0 = 1; we0 = 0; addr0 = 10'd10;
    tick();
    addr0 = 10'd11;
    chk("lat_memread", mem_memread, 1'b1);
    chk("lat_mem_addr_issue", mem_addr, 10'd10);
    tick();
    chk("lat_mem_addr_wait", mem_addr, 10'd10);
    tick();
    chk("lat_done0", done0, 1'b1);
    chk("lat_rdata0", rdata0, 32'hA0A0A0A0);
    req0 = 0;
    tick();

    // Reset pulsed during WAIT of a requester-1 read
    req1 = 1; we1 = 0; addr1 = 10'd11;
    tick();
    tick();
    chk("abort_busy_wait", busy, 1'b1);
    rst = 1;
    #1;
    chk_idle_zero("abort");
    req1 = 0;
    tick();
    chk("abort_done1_after", done1, 1'b0);
    tick();
    chk("abort_done1_later", done1, 1'b0);
    rst = 0;

    // Tie after reset: requester 0 wins first
    req0 = 1; we0 = 1; addr0 = 10'd20; wdata0 = 32'h12345678;
    req1 = 1; we1 = 1; addr1 = 10'd21; wdata1 = 32'h87654321;
    tick();
    chk("tie_mem_addr0", mem_addr, 10'd20);
    tick();
    chk("tie_done0", done0, 1'b1);
    chk("tie_done1_n", done1, 1'b0);
    req0 = 0;
    tick();
    tick();
    chk("tie_mem_addr1", mem_addr, 10'd21);
    chk("tie_mem_wdata1", mem_write_data, 32'h87654321);
    tick();
    chk("tie_done1", done1, 1'b1);
    req1 = 0;
    tick();

    // Requester 0 holds req across done: two writes, one done each
    req0 = 1; we0 = 1; addr0 = 10'd30; wdata0 = 32'h55;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (done0) dones++;
      chk("hold_done0", done0, (j == 2 || j == 5) ? 1'b1 : 1'b0);
      if (j == 5) req0 = 0;
    end
    chk("hold_done_count", dones, 2);
    chk("hold_idle_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
